// File: rtl/mc6800_bus_pkg.sv
// Purpose: shared types and constants for the 6800-style peripheral bus cycle generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus FSM state enum, user function-code constants, FC qualifier helper.
package mc6800_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_CE = 3'd1,
        CE      = 3'd2,
        TERM    = 3'd3,
        HOLD    = 3'd4,
        DRAIN   = 3'd5
    } busState_t;

    localparam logic [1:0] FC_UDATA = 2'b01;
    localparam logic [1:0] FC_UPROG = 2'b10;

    // Only user data / user program accesses are decoded to peripherals.
    function automatic logic isUserFc(input logic [1:0] fc);
        return (fc == FC_UDATA) || (fc == FC_UPROG);
    endfunction

endpackage

// File: rtl/e_clock_div.sv
// Purpose: free-running 6800 E clock divider, reusable for other 6800-family glue.
// Latency: eClk is registered and changes on the same edge as the divCnt value it reflects.
// Backpressure: none; runs continuously regardless of bus activity.
// Ports: sysClk/reset (async, active high); divCnt = 0..CLK_DIV-1 phase counter;
//        eClk high exactly while divCnt >= CLK_DIV/2.
module e_clock_div #(
    parameter int CLK_DIV = 25
) (
    input  logic                       sysClk,
    input  logic                       reset,
    output logic [$clog2(CLK_DIV)-1:0] divCnt,
    output logic                       eClk
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2);

    logic [CNT_W-1:0] nextCnt;

    assign nextCnt = (divCnt == LAST) ? '0 : divCnt + 1'b1;

    // eClk is computed from the next count so it stays in phase with divCnt.
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            divCnt <= '0;
            eClk   <= 1'b0;
        end else begin
            divCnt <= nextCnt;
            eClk   <= (nextCnt >= HALF);
        end
    end

endmodule

// File: rtl/mc6800_bus_cycle.sv
// Purpose: 68030-to-6800 peripheral bus cycle generator with per-device chip enables and 8-bit DSACK.
// Latency: match to nDsack[0] low in at most 2*CLK_DIV+1 sysClk cycles (E-period aligned).
// Backpressure: CPU is held by withholding DSACK; an aborted cycle drains to the end of the E period.
// Ports: sysClk, reset (async, active high); nAS, addr31, cpuFC, addrSel = CPU decode inputs;
//        nDsack ([1] tied 1, [0] active low), eClk, nCE (one-hot-low per device), busy (FSM not idle).
module mc6800_bus_cycle
    import mc6800_bus_pkg::*;
#(
    parameter int CLK_DIV  = 25,
    parameter int CE_START = 8,
    parameter int NUM_DEV  = 2,
    parameter int BASE_SEL = 1
) (
    input  logic               sysClk,
    input  logic               reset,
    input  logic               nAS,
    input  logic               addr31,
    input  logic [1:0]         cpuFC,
    input  logic [2:0]         addrSel,
    output logic [1:0]         nDsack,
    output logic               eClk,
    output logic [NUM_DEV-1:0] nCE,
    output logic               busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CE_CNT   = CNT_W'(CE_START);
    localparam logic [CNT_W-1:0] WRAP_CNT = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0]       SEL_LO   = 4'(BASE_SEL);
    localparam logic [3:0]       SEL_HI   = 4'(BASE_SEL + NUM_DEV);

    if (CLK_DIV < 4) begin : gBadClkDiv
        $error("mc6800_bus_cycle: CLK_DIV must be >= 4");
    end
    if (CE_START >= CLK_DIV / 2) begin : gBadCeStart
        $error("mc6800_bus_cycle: CE_START must be < CLK_DIV/2");
    end
    if (NUM_DEV < 1 || NUM_DEV > 8) begin : gBadNumDev
        $error("mc6800_bus_cycle: NUM_DEV must be 1..8");
    end
    if (BASE_SEL < 0 || BASE_SEL + NUM_DEV > 8) begin : gBadBaseSel
        $error("mc6800_bus_cycle: BASE_SEL+NUM_DEV must be <= 8");
    end

    logic [CNT_W-1:0] divCnt;
    busState_t        state;
    logic [2:0]       devIdx;
    logic [3:0]       selExt;
    logic             match;
    logic             ceOn;

    e_clock_div #(
        .CLK_DIV (CLK_DIV)
    ) uDiv (
        .sysClk (sysClk),
        .reset  (reset),
        .divCnt (divCnt),
        .eClk   (eClk)
    );

    // One extra bit so BASE_SEL+NUM_DEV == 8 compares correctly.
    assign selExt = {1'b0, addrSel};
    assign match  = !nAS && addr31 && isUserFc(cpuFC) &&
                    (selExt >= SEL_LO) && (selExt < SEL_HI);

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            devIdx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state  <= WAIT_CE;
                        devIdx <= addrSel - 3'(BASE_SEL);
                    end
                end
                WAIT_CE: begin
                    if (nAS)                   state <= IDLE;
                    else if (divCnt == CE_CNT) state <= CE;
                end
                CE: begin
                    // Once the peripheral is enabled the E period must run to completion.
                    if (nAS)                     state <= DRAIN;
                    else if (divCnt == WRAP_CNT) state <= TERM;
                end
                TERM: begin
                    state <= nAS ? IDLE : HOLD;
                end
                HOLD: begin
                    if (nAS) state <= IDLE;
                end
                DRAIN: begin
                    if (divCnt == WRAP_CNT) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // TERM keeps the chip enable one cycle past the E falling edge for data hold.
    assign ceOn = (state == CE) || (state == TERM) || (state == DRAIN);

    always_comb begin
        nCE = '1;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (ceOn && (devIdx == 3'(i))) nCE[i] = 1'b0;
        end
    end

    assign nDsack = {1'b1, !((state == TERM) || (state == HOLD))};
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mc6800_bus_cycle.sv
module tb_mc6800_bus_cycle;

    logic       sysClk = 1'b0;
    logic       reset  = 1'b1;
    logic       nAsA   = 1'b1;
    logic       nAsB   = 1'b1;
    logic       addr31 = 1'b0;
    logic [1:0] cpuFC  = 2'b00;
    logic [2:0] addrSel = 3'd0;

    logic [1:0] nDsackA, nDsackB;
    logic       eClkA, eClkB, busyA, busyB;
    logic [1:0] nCeA;
    logic [3:0] nCeB;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // sysClk edges since reset release == expected divider phase count

    always #5 sysClk = ~sysClk;

    mc6800_bus_cycle uDutA (
        .sysClk  (sysClk),
        .reset   (reset),
        .nAS     (nAsA),
        .addr31  (addr31),
        .cpuFC   (cpuFC),
        .addrSel (addrSel),
        .nDsack  (nDsackA),
        .eClk    (eClkA),
        .nCE     (nCeA),
        .busy    (busyA)
    );

    mc6800_bus_cycle #(
        .CLK_DIV  (10),
        .CE_START (2),
        .NUM_DEV  (4),
        .BASE_SEL (4)
    ) uDutB (
        .sysClk  (sysClk),
        .reset   (reset),
        .nAS     (nAsB),
        .addr31  (addr31),
        .cpuFC   (cpuFC),
        .addrSel (addrSel),
        .nDsack  (nDsackB),
        .eClk    (eClkB),
        .nCE     (nCeB),
        .busy    (busyB)
    );

    function automatic int pDiv(input int dut);   return (dut == 0) ? 25 : 10; endfunction
    function automatic int pCe(input int dut);    return (dut == 0) ? 8  : 2;  endfunction
    function automatic int pBase(input int dut);  return (dut == 0) ? 1  : 4;  endfunction
    function automatic int pNum(input int dut);   return (dut == 0) ? 2  : 4;  endfunction

    // Smallest edge index e >= from with e mod d == m.
    function automatic int firstAt(input int from, input int m, input int d);
        int e;
        e = from;
        while ((e % d) != m) e++;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic checkOut(input int dut, input bit expBusy, input bit ceOn, input int idx, input bit dsOn);
        logic [7:0] expCe;
        logic [7:0] obsCe;
        logic [1:0] obsDs;
        logic       obsE, obsBusy, expE;
        int         d;
        d     = pDiv(dut);
        expE  = ((cyc % d) >= (d / 2));
        expCe = 8'hFF;
        if (ceOn) expCe[idx] = 1'b0;
        if (dut == 0) begin
            obsCe = {6'h3F, nCeA}; obsDs = nDsackA; obsE = eClkA; obsBusy = busyA;
        end else begin
            obsCe = {4'hF, nCeB};  obsDs = nDsackB; obsE = eClkB; obsBusy = busyB;
        end
        chk("eClk",   {7'd0, obsE},    {7'd0, expE});
        chk("busy",   {7'd0, obsBusy}, {7'd0, expBusy});
        chk("nCE",    obsCe,           expCe);
        chk("nDsack", {6'd0, obsDs},   {6'd0, 1'b1, !dsOn});
    endtask

    task automatic setNas(input int dut, input logic v);
        if (dut == 0) nAsA = v; else nAsB = v;
    endtask

    task automatic scramble();
        addrSel = 3'($urandom);
        cpuFC   = 2'($urandom);
        addr31  = 1'($urandom);
    endtask

    task automatic idleCycles(input int dut, input int n);
        for (int k = 0; k < n; k++) begin
            setNas(dut, 1'b1);
            scramble();
            @(posedge sysClk); cyc++; #1;
            checkOut(dut, 1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic waitPhase(input int dut, input int p);
        int d;
        d = pDiv(dut);
        idleCycles(dut, (p - (cyc % d) + d) % d);
    endtask

    // Access with nAS low for lowLen edges. Expected behaviour is derived from
    // edge arithmetic: CE starts after the edge sampling divCnt==CE_START,
    // terminates on the next wrap, and an abort during CE drains to a wrap.
    task automatic runTxn(input int dut, input logic [2:0] sel, input logic [1:0] fc,
                          input logic a31, input int lowLen, input int gap);
        int  d, a, r, idx, last;
        int  ceEdge, termEdge, busyEnd, ceFrom, ceTo, dsFrom, dsTo;
        bit  m;
        d   = pDiv(dut);
        a   = cyc;
        r   = a + lowLen + 1;
        idx = int'(sel) - pBase(dut);
        m   = a31 && (fc == 2'b01 || fc == 2'b10) &&
              (int'(sel) >= pBase(dut)) && (int'(sel) < pBase(dut) + pNum(dut));
        busyEnd = a + 1; ceFrom = 1; ceTo = 0; dsFrom = 1; dsTo = 0;
        if (m) begin
            ceEdge   = firstAt(a + 1, pCe(dut), d) + 1;
            termEdge = firstAt(ceEdge + 1, 0, d);
            if (r <= ceEdge) begin
                busyEnd = r;
            end else if (r <= termEdge) begin
                busyEnd = firstAt(r + 1, 0, d);
                ceFrom  = ceEdge;
                ceTo    = busyEnd - 1;
            end else begin
                busyEnd = r;
                ceFrom  = ceEdge;
                ceTo    = termEdge;
                dsFrom  = termEdge;
                dsTo    = r - 1;
            end
        end
        last = ((busyEnd > r) ? busyEnd : r) + gap;
        addrSel = sel; cpuFC = fc; addr31 = a31;
        for (int n = a + 1; n <= last; n++) begin
            if (n <= a + lowLen) setNas(dut, 1'b0);
            else begin
                setNas(dut, 1'b1);
                scramble();
            end
            @(posedge sysClk); cyc++; #1;
            checkOut(dut, (n < busyEnd), (n >= ceFrom && n <= ceTo), idx,
                     (n >= dsFrom && n <= dsTo));
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge sysClk);
        #1;
        checkOut(0, 1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        cyc   = 0;
        checkOut(0, 1'b0, 1'b0, 0, 1'b0);
        checkOut(1, 1'b0, 1'b0, 0, 1'b0);

        // Default configuration: device 0 and device 1, match at divCnt 3.
        waitPhase(0, 3);
        runTxn(0, 3'd1, 2'b01, 1'b1, 60, 2);
        waitPhase(0, 3);
        runTxn(0, 3'd2, 2'b10, 1'b1, 55, 1);

        // Non-decoded accesses stay silent.
        runTxn(0, 3'd0, 2'b01, 1'b1, 60, 0);
        runTxn(0, 3'd3, 2'b01, 1'b1, 60, 0);
        runTxn(0, 3'd1, 2'b11, 1'b1, 60, 0);
        runTxn(0, 3'd1, 2'b00, 1'b1, 60, 0);
        runTxn(0, 3'd1, 2'b01, 1'b0, 60, 0);

        // Match past CE_START waits for the next E period.
        waitPhase(0, 10);
        runTxn(0, 3'd1, 2'b01, 1'b1, 60, 0);

        // Abort during CE at divCnt 15: drain to the wrap, no DSACK.
        waitPhase(0, 3);
        runTxn(0, 3'd2, 2'b01, 1'b1, 12, 3);

        // Back-to-back with minimum gap.
        runTxn(0, 3'd1, 2'b10, 1'b1, 50, 0);
        runTxn(0, 3'd2, 2'b01, 1'b1, 50, 0);

        for (int t = 0; t < 20; t++) begin
            idleCycles(0, $urandom_range(0, 24));
            runTxn(0, 3'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                   $urandom_range(1, 70), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of CE.
        waitPhase(0, 3);
        addrSel = 3'd1; cpuFC = 2'b01; addr31 = 1'b1; nAsA = 1'b0;
        repeat (10) begin
            @(posedge sysClk); cyc++;
        end
        #1;
        checkOut(0, 1'b1, 1'b1, 0, 1'b0);
        #1 reset = 1'b1;
        nAsA = 1'b1;
        #1;
        cyc = 0;
        checkOut(0, 1'b0, 1'b0, 0, 1'b0);
        checkOut(1, 1'b0, 1'b0, 0, 1'b0);
        #1 reset = 1'b0;
        idleCycles(0, 30);

        // Alternate configuration: 4 devices from select code 4, 10-cycle E.
        idleCycles(1, 3);
        runTxn(1, 3'd7, 2'b01, 1'b1, 30, 1);
        runTxn(1, 3'd3, 2'b01, 1'b1, 30, 0);
        waitPhase(1, 5);
        runTxn(1, 3'd4, 2'b10, 1'b1, 25, 0);
        runTxn(1, 3'd5, 2'b01, 1'b1, 6, 2);
        for (int t = 0; t < 15; t++) begin
            idleCycles(1, $urandom_range(0, 9));
            runTxn(1, 3'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                   $urandom_range(1, 30), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
